// File: rtl/lcd_pixel_outfifo_if.sv
// Push-side bus between the pixel pipeline and the panel output FIFO.
// Latency: none; bundles wiring only.
// Backpressure: full/almost_full/level flow back to the pipeline.
interface lcd_pixel_outfifo_if #(
  parameter int DW = 24,
  parameter int AW = 4
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic [AW:0]   level;

  // Pixel pipeline side
  modport master (
    output wr_en, wr_data,
    input  full, almost_full, level
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data,
    output full, almost_full, level
  );
endinterface

// File: rtl/lcd_pixel_outfifo.sv
// Pixel output FIFO feeding the panel data pins; pops follow TFT active / STN read.
// Latency: popped word on lcd_data one cycle after the pop; gated to zero outside data.
// Backpressure: almost_full to the pipeline; pushes while full without a pop are dropped.
// Optional: LCD_OUTFIFO_STATS_EN adds a saturating underflow counter uf_count.
module lcd_pixel_outfifo #(
  parameter int DW           = 24,
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lcden,
  input  logic                lcdtft,
  input  logic                vsync,
  input  logic                read,
  input  logic                active,
  input  logic                underflow_clr,
  lcd_pixel_outfifo_if.slave  pix,
  output logic [DW-1:0]       lcd_data,
`ifdef LCD_OUTFIFO_STATS_EN
  output logic [15:0]         uf_count,
`endif
  output logic                underflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_THRESH);

  state_t        state, state_nxt;
  logic          vsync_d;
  logic          frame_uf;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q;
  logic          full_q, afull_q;
  logic [DW-1:0] mem [DEPTH];

  logic          run_ok;
  logic          pop_req;
  logic          pop_ok;
  logic          push_ok;
  logic          uf_evt;
  logic          vsync_rise;
  logic [AW:0]   level_nxt;

  assign pix.level       = level_q;
  assign pix.full        = full_q;
  assign pix.almost_full = afull_q;

  // FSM state register plus vsync edge-detect delay
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      vsync_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_d <= vsync;
    end
  end

  // FSM next state: resync only when this frame actually underflowed
  always_comb begin
    state_nxt  = state;
    vsync_rise = vsync & ~vsync_d;
    case (state)
      S_IDLE:   if (lcden) state_nxt = S_RUN;
      S_RUN: begin
        if (!lcden)                      state_nxt = S_IDLE;
        else if (vsync_rise && frame_uf) state_nxt = S_RESYNC;
      end
      S_RESYNC: state_nxt = lcden ? S_RUN : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Push/pop qualification and next occupancy; the leaving-RUN cycle is treated as a flush
  always_comb begin
    run_ok    = (state == S_RUN) && lcden;
    pop_req   = run_ok && (lcdtft ? active : read);
    pop_ok    = pop_req && (level_q != '0);
    uf_evt    = pop_req && (level_q == '0);
    push_ok   = run_ok && pix.wr_en && (!full_q || pop_ok);
    level_nxt = level_q;
    if (push_ok && !pop_ok)      level_nxt = level_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) level_nxt = level_q - (AW+1)'(1);
  end

  // Storage write; no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pix.wr_data;
  end

  // Pointers, occupancy and registered flags, cleared whenever not running
  always_ff @(posedge clk) begin
    if (reset || !run_ok) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_FULL);
      afull_q <= (level_nxt >= LVL_AFULL);
    end
  end

  // Panel data: load on pop, TFT zero otherwise, STN holds through active then zeroes
  always_ff @(posedge clk) begin
    if (reset || !run_ok)             lcd_data <= '0;
    else if (pop_ok)                  lcd_data <= mem[rd_ptr];
    else if (lcdtft || !active || uf_evt) lcd_data <= '0;
  end

  // Per-frame underflow marker, dropped once the FIFO has been resynced or idled
  always_ff @(posedge clk) begin
    if (reset || state != S_RUN) frame_uf <= 1'b0;
    else if (uf_evt)             frame_uf <= 1'b1;
  end

  // Sticky underflow flag; a fresh underflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)              underflow <= 1'b0;
    else if (uf_evt)        underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

`ifdef LCD_OUTFIFO_STATS_EN
  // Saturating underflow counter; clear with a concurrent underflow restarts at one
  always_ff @(posedge clk) begin
    if (reset)                             uf_count <= '0;
    else if (underflow_clr)                uf_count <= uf_evt ? 16'd1 : 16'd0;
    else if (uf_evt && uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lcd_pixel_outfifo.sv
// Directed bench for the panel output FIFO.
// Latency: inputs driven 1 time unit after posedge, outputs checked there too.
// Backpressure: full/almost_full/level checked against hand-computed values.
module tb_lcd_pixel_outfifo;
  logic        clk = 1'b0;
  logic        reset, lcden, lcdtft, vsync, read, active, underflow_clr;
  logic [23:0] lcd_data;
  logic        underflow;
`ifdef LCD_OUTFIFO_STATS_EN
  logic [15:0] uf_count;
`endif
  int checks = 0;
  int errors = 0;

  lcd_pixel_outfifo_if #(.DW(24), .AW(4)) pif ();

  lcd_pixel_outfifo dut (
    .clk           (clk),
    .reset         (reset),
    .lcden         (lcden),
    .lcdtft        (lcdtft),
    .vsync         (vsync),
    .read          (read),
    .active        (active),
    .underflow_clr (underflow_clr),
    .pix           (pif),
    .lcd_data      (lcd_data),
`ifdef LCD_OUTFIFO_STATS_EN
    .uf_count      (uf_count),
`endif
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [23:0] start, input int n);
    pif.wr_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      pif.wr_data = start + 24'(k);
      tick();
    end
    pif.wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lcden = 1'b0; lcdtft = 1'b1; vsync = 1'b0; read = 1'b0;
    active = 1'b0; underflow_clr = 1'b0; pif.wr_en = 1'b0; pif.wr_data = '0;
    tick(); tick();
    chk("rst_level", 32'(pif.level), 0);
    chk("rst_full", 32'(pif.full), 0);
    chk("rst_afull", 32'(pif.almost_full), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_uf", 32'(underflow), 0);
    reset = 1'b0;
    tick();

    // Fill to full, watch almost_full threshold, then overflow push is dropped
    lcden = 1'b1;
    tick();
    pif.wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      pif.wr_data = 24'(i);
      tick();
      chk("fill_level", 32'(pif.level), 32'(i));
      chk("fill_afull", 32'(pif.almost_full), (i >= 12) ? 1 : 0);
      chk("fill_full", 32'(pif.full), (i == 16) ? 1 : 0);
    end
    pif.wr_data = 24'h000099;
    tick();
    pif.wr_en = 1'b0;
    chk("ovf_level", 32'(pif.level), 16);
    chk("ovf_full", 32'(pif.full), 1);

    // Drain all 16 in TFT mode: order preserved, no trace of the dropped word
    active = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("drain_data", 32'(lcd_data), 32'(i));
      if (i == 16) active = 1'b0;
    end
    tick();
    chk("drain_gap", 32'(lcd_data), 0);
    chk("drain_level", 32'(pif.level), 0);
    chk("drain_uf", 32'(underflow), 0);

    // TFT: four words out on the four cycles after active rises
    push_n(24'd1, 4);
    active = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("tft_data", 32'(lcd_data), 32'(i));
      if (i == 4) active = 1'b0;
    end
    tick();
    chk("tft_gap", 32'(lcd_data), 0);
    chk("tft_level", 32'(pif.level), 0);

    // STN: vsync with no underflow is harmless, then each read word held 3 cycles
    lcdtft = 1'b0;
    push_n(24'h000100, 3);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    chk("vs_noop_level", 32'(pif.level), 3);
    active = 1'b1;
    for (int w = 0; w < 3; w++) begin
      read = 1'b1;
      tick();
      read = 1'b0;
      chk("stn_load", 32'(lcd_data), 32'h100 + 32'(w));
      tick();
      chk("stn_hold1", 32'(lcd_data), 32'h100 + 32'(w));
      tick();
      chk("stn_hold2", 32'(lcd_data), 32'h100 + 32'(w));
    end
    active = 1'b0;
    tick();
    chk("stn_off", 32'(lcd_data), 0);
    chk("stn_level", 32'(pif.level), 0);
    chk("stn_uf", 32'(underflow), 0);

    // Underflow on empty FIFO in TFT mode
    lcdtft = 1'b1;
    active = 1'b1;
    tick();
    chk("uf_flag1", 32'(underflow), 1);
    chk("uf_data1", 32'(lcd_data), 0);
    tick();
    active = 1'b0;
    chk("uf_flag2", 32'(underflow), 1);
    chk("uf_data2", 32'(lcd_data), 0);
`ifdef LCD_OUTFIFO_STATS_EN
    chk("uf_cnt2", 32'(uf_count), 2);
`endif
    underflow_clr = 1'b1;
    active = 1'b1;
    tick();
    active = 1'b0;
    chk("uf_clr_race", 32'(underflow), 1);
`ifdef LCD_OUTFIFO_STATS_EN
    chk("uf_cnt_race", 32'(uf_count), 1);
`endif
    tick();
    underflow_clr = 1'b0;
    chk("uf_clr", 32'(underflow), 0);
`ifdef LCD_OUTFIFO_STATS_EN
    chk("uf_cnt_clr", 32'(uf_count), 0);
`endif

    // Vsync rise after an underflowing frame: one resync cycle drops the push
    vsync = 1'b1;
    tick();
    pif.wr_en = 1'b1;
    pif.wr_data = 24'h000055;
    tick();
    pif.wr_en = 1'b0;
    vsync = 1'b0;
    chk("resync_drop", 32'(pif.level), 0);
    pif.wr_en = 1'b1;
    pif.wr_data = 24'h000300;
    tick();
    chk("resync_one_cycle", 32'(pif.level), 1);
    push_n(24'h000301, 7);
    chk("lvl8", 32'(pif.level), 8);
    chk("lvl8_afull", 32'(pif.almost_full), 0);

    // Push+pop every cycle at level 8; write pointer wraps, order preserved
    active = 1'b1;
    pif.wr_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pif.wr_data = 24'h000308 + 24'(k);
      tick();
      chk("pp_data", 32'(lcd_data), 32'h300 + 32'(k));
      chk("pp_level", 32'(pif.level), 8);
    end
    pif.wr_en = 1'b0;

    // Pop down to 5, then drop lcden with active still high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pop_data", 32'(lcd_data), 32'h30A + 32'(k));
    end
    chk("lvl5", 32'(pif.level), 5);
    lcden = 1'b0;
    tick();
    active = 1'b0;
    chk("dis_level", 32'(pif.level), 0);
    chk("dis_data", 32'(lcd_data), 0);
    chk("dis_uf", 32'(underflow), 0);
    lcden = 1'b1;
    tick();

    // Reset mid-stream with underflow set and data on the pins
    active = 1'b1;
    tick();
    active = 1'b0;
    push_n(24'h0000AB, 2);
    active = 1'b1;
    tick();
    chk("pre_rst_data", 32'(lcd_data), 32'hAB);
    chk("pre_rst_uf", 32'(underflow), 1);
    reset = 1'b1;
    tick();
    active = 1'b0;
    chk("mid_rst_level", 32'(pif.level), 0);
    chk("mid_rst_data", 32'(lcd_data), 0);
    chk("mid_rst_uf", 32'(underflow), 0);
    chk("mid_rst_full", 32'(pif.full), 0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
